// File: rtl/instr_encoder.sv
// instr_encoder
// Streaming RISC-V instruction encoder/loader. Takes instruction fields plus a
// 32-bit signed immediate, packs them into an I-type or S-type word and
// emits each word with a sequential instruction-memory byte address.
//
// Optional feature macro: INSTR_ENCODER_CHECK_EN
//   defined   : immediate/format legality check, HALT state, sticky range_err
//   undefined : no check, immediate truncated, imm_source 1x packs as I-type
//               with a zero immediate field, range_err tied 0
//
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   clear                 synchronous restart (counters, error, output reg)
//   in_valid / in_ready   field beat handshake
//   imm_source            00 I-type, 01 S-type, 1x unsupported
//   imm_value             signed immediate
//   opcode, funct3        opcode and funct3 fields
//   rd, rs1, rs2          register fields
//   out_valid / out_ready encoded word handshake
//   out_instr, out_addr   encoded word and its byte write address
//   word_count            words accepted since reset/clear
//   full                  word_count == MAX_WORDS
//   range_err             sticky: a beat was rejected
module instr_encoder #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int unsigned MAX_WORDS = 256
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         clear,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [1:0]                   imm_source,
    input  logic [31:0]                  imm_value,
    input  logic [6:0]                   opcode,
    input  logic [2:0]                   funct3,
    input  logic [4:0]                   rd,
    input  logic [4:0]                   rs1,
    input  logic [4:0]                   rs2,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [31:0]                  out_instr,
    output logic [31:0]                  out_addr,
    output logic [$clog2(MAX_WORDS):0]   word_count,
    output logic                         full,
    output logic                         range_err
);

    localparam int unsigned CW = $clog2(MAX_WORDS) + 1;
    localparam logic [CW-1:0] MAX_CNT = CW'(MAX_WORDS);

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } state_t;

    state_t      state;
    logic        accept;
    logic        legal;
    logic [31:0] packed_word;
    logic [31:0] next_addr;

    assign full     = (word_count == MAX_CNT);
    assign in_ready = rst_n && (state == RUN) && !full && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;

    // Address of the word being accepted uses the pre-increment count.
    assign next_addr = BASE_ADDR + (32'(word_count) << 2);

`ifdef INSTR_ENCODER_CHECK_EN
    // Legal only when the 12-bit field sign-extends back to imm_value.
    assign legal = !imm_source[1] && ((&imm_value[31:11]) || !(|imm_value[31:11]));
`else
    assign legal = 1'b1;
    logic unused_imm_hi;
    assign unused_imm_hi = ^imm_value[31:12];
`endif

    always_comb begin
        packed_word = '0;
        if (imm_source == 2'b01) begin
            packed_word = {imm_value[11:5], rs2, rs1, funct3, imm_value[4:0], opcode};
        end else if (imm_source == 2'b00) begin
            packed_word = {imm_value[11:0], rs1, funct3, rd, opcode};
        end else begin
            packed_word = {12'h000, rs1, funct3, rd, opcode};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            state      <= RUN;
            out_valid  <= 1'b0;
            out_instr  <= '0;
            out_addr   <= BASE_ADDR;
            word_count <= '0;
`ifdef INSTR_ENCODER_CHECK_EN
            range_err  <= 1'b0;
`endif
        end else begin
            // Drain first; a same-edge accept below overrides and keeps valid high.
            if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
            if (accept) begin
                if (legal) begin
                    out_valid  <= 1'b1;
                    out_instr  <= packed_word;
                    out_addr   <= next_addr;
                    word_count <= word_count + 1'b1;
                end else begin
`ifdef INSTR_ENCODER_CHECK_EN
                    state     <= HALT;
                    range_err <= 1'b1;
`endif
                end
            end
        end
    end

`ifndef INSTR_ENCODER_CHECK_EN
    assign range_err = 1'b0;
`endif

endmodule

// File: doc/instr_encoder.md
# instr_encoder

Streaming RISC-V instruction encoder and loader. It is the inverse of the decode-side immediate extractor. It accepts instruction fields plus a 32-bit signed immediate and packs them into I-type or S-type instruction words. Each word carries a sequential instruction-memory write address. It sits between the test/boot loader and the instruction memory write port, and is usable by benches to build programs in-sim.

## Interface
Parameters:
- BASE_ADDR, 32'h0000_0000, byte address of the first emitted word
- MAX_WORDS, 256, number of words accepted before `full`; power of two, ≥2

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  synchronous active-low reset
- clear  in  1  synchronous restart: counters, error, output register cleared
- in_valid  in  1  field beat valid
- in_ready  out  1  beat accepted when in_valid & in_ready
- imm_source  in  2  00 I-type, 01 S-type, 1x unsupported
- imm_value  in  32  signed immediate
- opcode  in  7  opcode field
- funct3  in  3  funct3 field
- rd  in  5  destination register (I-type)
- rs1  in  5  source register 1
- rs2  in  5  source register 2 (S-type)
- out_valid  out  1  encoded word valid
- out_ready  in  1  consumer accepts word
- out_instr  out  32  encoded instruction
- out_addr  out  32  byte write address of out_instr
- word_count  out  $clog2(MAX_WORDS)+1  words accepted since reset/clear
- full  out  1  word_count == MAX_WORDS
- range_err  out  1  sticky: a beat was rejected

## Operation
- I-type packing: {imm_value[11:0], rs1, funct3, rd, opcode}.
- S-type packing: {imm_value[11:5], rs2, rs1, funct3, imm_value[4:0], opcode}.
- Round-trip rule: sign-extending the packed 12-bit immediate reproduces imm_value whenever the beat is legal.
- Legal beat:
  - imm_source ∈ {00,01}; and
  - imm_value[31:11] is all-zeros or all-ones.
- States:
  - RUN: normal operation.
  - HALT: entered on an accepted illegal beat. The beat is dropped (no output, no count), range_err is set, and in_ready=0. HALT is left only via clear or reset.
- in_ready = (state==RUN) & !full & (!out_valid | out_ready).
- Accepted legal beat:
  - Output register loads out_instr.
  - out_addr = BASE_ADDR + 4·word_count (pre-increment value).
  - word_count increments.
- full rises when word_count reaches MAX_WORDS. Further beats stall; there is no wrap-around. clear restarts at BASE_ADDR.
- Priority: rst_n > clear > accept/emit. clear discards any pending out_valid word.

## Timing
- Reset values:
  - out_valid=0, out_instr=0, out_addr=BASE_ADDR, word_count=0, full=0, range_err=0, state=RUN.
  - in_ready is 0 while rst_n=0 and 1 in the first cycle after.
- Latency: a beat accepted at edge N gives out_valid=1 with data after edge N (1 cycle).
- Throughput: 1 word/cycle when out_ready is held high.
- Output hold: out_instr and out_addr are stable while out_valid & !out_ready. out_valid drops only after a handshake with no new accept in the same cycle.
- Simultaneous emit + accept: the output register reloads in the same edge and out_valid stays 1.
- Illegal beat at edge N: range_err=1 and state=HALT after N. A pending legal word still drains normally.
- Reset or clear mid-stream: everything returns to reset values at that edge and pending data is lost.

## Configuration
- INSTR_ENCODER_CHECK_EN defined:
  - Legality check, HALT state and range_err are implemented as above.
- Undefined:
  - No check and no HALT; range_err is tied 0.
  - imm_value bits are truncated silently.
  - imm_source 1x packs as I-type with a zero immediate field.

## Test plan
- I-type: opcode=7'h13, funct3=0, rd=5, rs1=6, imm=-1 → out_instr=32'hFFF30293, out_addr=BASE_ADDR, 1-cycle latency.
- S-type: opcode=7'h23, funct3=2, rs1=2, rs2=8, imm=12 → out_instr=32'h00812623; a second beat gets out_addr=BASE_ADDR+4.
- Backpressure: out_ready=0 for 5 cycles with 3 beats offered → only 1 accepted, output held stable; release → stream resumes at 1/cycle with no loss or duplicate.
- Range (macro defined): imm=2048 → range_err=1, in_ready=0, word_count unchanged; clear → RUN, out_addr back to BASE_ADDR.
- Full: MAX_WORDS=4, feed 6 beats → 4 emitted, last out_addr=BASE_ADDR+12, full=1, in_ready=0.
- Reset mid-stream with out_valid=1, out_ready=0 → after the rst_n=0 edge all outputs are at reset values.
